rom_dump_sequencer: RTL
=======================

ROM_DUMP_SEQUENCER -- requirements
Module: rom_dump_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, chip data width (4 for 3601).
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 9, chip address width (8 for 3601).
REQ-003 The block SHALL have parameter LAST_ADDRESS, default 511, final address dumped (255 for 3601).
REQ-004 The block SHALL have parameter SETTLE_CYCLES, default 4, range 1..255, access-time wait cycles per address.
REQ-005 The block SHALL have the port: clk  input  1  clock; all logic on rising edge.
REQ-006 The block SHALL have the port: reset_n  input  1  reset, synchronous, active-low.
REQ-007 The block SHALL have the port: start  input  1  begin dump; level-sampled in IDLE only.
REQ-008 The block SHALL have the port: abort  input  1  cancel dump from any state.
REQ-009 The block SHALL have the port: chip_data_in  input  DATA_WIDTH  data lines from the ROM socket.
REQ-010 The block SHALL have the port: chip_address  output  ADDRESS_WIDTH  address driven to the ROM.
REQ-011 The block SHALL have the port: chip_operation  output  4  V1..V4 control; bit0=V1 ... bit3=V4.
REQ-012 The block SHALL have the port: out_data  output  DATA_WIDTH  captured word.
REQ-013 The block SHALL have the port: out_address  output  ADDRESS_WIDTH  address of out_data.
REQ-014 The block SHALL have the port: out_valid  output  1  out_data/out_address valid.
REQ-015 The block SHALL have the port: out_ready  input  1  downstream (UART/host) accepts word.
REQ-016 The block SHALL have the port: busy  output  1  high in every state except IDLE.
REQ-017 The block SHALL have the port: done  output  1  one-cycle pulse at dump completion.
REQ-018 The block SHALL have the port: checksum  output  16  modulo-2^16 sum of all words captured since last start.

Function
REQ-019 The FSM SHALL have states IDLE, SETTLE, CAPTURE, SEND, FINISH.
REQ-020 In IDLE with start=1, the next state SHALL be SETTLE, with chip_address=0, checksum=0, settle counter=0.
REQ-021 chip_operation SHALL be 4'b1100 in SETTLE, CAPTURE and SEND, and 4'b0000 in IDLE and FINISH.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then transition to CAPTURE.
REQ-023 chip_address SHALL be stable throughout SETTLE, CAPTURE and SEND.
REQ-024 CAPTURE SHALL last one cycle and register out_data<=chip_data_in, out_address<=chip_address, checksum<=checksum+zero-extended chip_data_in; next state SEND.
REQ-025 In SEND, out_valid SHALL be 1 and out_data/out_address SHALL be held until a cycle with out_ready=1.
REQ-026 On a SEND handshake with chip_address!=LAST_ADDRESS, chip_address SHALL increment by 1 and the FSM SHALL return to SETTLE with counter cleared.
REQ-027 On a SEND handshake with chip_address==LAST_ADDRESS, the FSM SHALL go to FINISH; chip_address SHALL NOT wrap.
REQ-028 FINISH SHALL last one cycle with done=1, then go to IDLE; checksum and out_data SHALL hold until the next start.
REQ-029 out_valid SHALL be 0 outside SEND; out_ready SHALL be ignored outside SEND.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 abort=1 in any state SHALL force IDLE on the next edge with out_valid=0, chip_operation=0, done=0; abort SHALL take priority over start and handshake.
REQ-032 Latency per word with out_ready held high SHALL be SETTLE_CYCLES+2 cycles; a full dump SHALL take (LAST_ADDRESS+1)*(SETTLE_CYCLES+2)+1 cycles from start to done.

Reset
REQ-033 With reset_n=0 at a clock edge, the block SHALL enter IDLE with chip_address=0, chip_operation=0, out_data=0, out_address=0, out_valid=0, busy=0, done=0, checksum=0, settle counter=0.
REQ-034 Reset SHALL take priority over abort and start, including mid-dump.

Verification
REQ-035 Bench SHALL cover: ROM model data=addr[7:0], out_ready=1, start pulse -> 512 words 0x00..0xFF twice, checksum=0xFF00, done after 512*6+1 cycles.
REQ-036 Bench SHALL cover: out_ready low 10 cycles at address 5 -> out_valid held, out_data=0x05, chip_address=5 stable, no checksum change.
REQ-037 Bench SHALL cover: abort at address 100 in SETTLE -> IDLE next cycle, busy=0, done never pulses; a new start restarts at address 0 with checksum=0.
REQ-038 Bench SHALL cover: reset_n=0 during SEND at address 300 -> all outputs at reset values next edge.
REQ-039 Bench SHALL cover: DATA_WIDTH=4, ADDRESS_WIDTH=8, LAST_ADDRESS=255, data=0xF -> 256 words, checksum=0x0F00, no wrap past 255.
REQ-040 Bench SHALL cover: start held high through the dump -> single dump, done once, then a new dump begins from IDLE.

Source files
------------

// File: rtl/rom_dump_sequencer.sv
// ---------------------------------------------------------------------------
// rom_dump_sequencer
//
// Walks a parallel ROM (e.g. a 3601 PROM in a test socket) from address 0 up
// to LAST_ADDRESS. For each address it:
//   1. Drives the address and waits SETTLE_CYCLES clocks for access time.
//   2. Captures the data lines.
//   3. Offers the captured word to a downstream consumer with a
//      valid/ready handshake.
// A running 16-bit checksum of every captured word is kept for the host.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   reset_n        : synchronous, active-low reset
//   start          : begin a dump (only looked at while idle)
//   abort          : cancel the dump from any state
//   chip_data_in   : data lines from the ROM socket
//   chip_address   : address driven to the ROM
//   chip_operation : V1..V4 socket supply control (bit0 = V1 ... bit3 = V4)
//   out_data       : captured word
//   out_address    : address that out_data was read from
//   out_valid      : out_data/out_address are being offered
//   out_ready      : downstream accepts the offered word
//   busy           : high whenever a dump is in progress
//   done           : one-cycle pulse when the last word has been accepted
//   checksum       : modulo-2^16 sum of all words captured since start
// ---------------------------------------------------------------------------
module rom_dump_sequencer #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 9,
   parameter int LAST_ADDRESS  = 511,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [DATA_WIDTH-1:0]    chip_data_in,
   output logic [ADDRESS_WIDTH-1:0] chip_address,
   output logic [3:0]               chip_operation,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [ADDRESS_WIDTH-1:0] out_address,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              checksum
);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      SEND,
      FINISH
   } state_t;

   // Supply pattern that powers the ROM for a read; all rails off otherwise.
   localparam logic [3:0]               READ_OPERATION = 4'b1100;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR      = ADDRESS_WIDTH'(LAST_ADDRESS);
   localparam logic [7:0]               SETTLE_LAST    = 8'(SETTLE_CYCLES - 1);

   state_t                     state;
   state_t                     state_next;
   logic [7:0]                 settle_count;
   logic [7:0]                 settle_count_next;
   logic [ADDRESS_WIDTH-1:0]   address_next;
   logic [DATA_WIDTH-1:0]      out_data_next;
   logic [ADDRESS_WIDTH-1:0]   out_address_next;
   logic [15:0]                checksum_next;

   // State and datapath registers. Reset clears everything; otherwise every
   // register simply takes the value chosen by the combinational block below,
   // so all hold/update decisions live in one place.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         settle_count <= '0;
         chip_address <= '0;
         out_data     <= '0;
         out_address  <= '0;
         checksum     <= '0;
      end else begin
         state        <= state_next;
         settle_count <= settle_count_next;
         chip_address <= address_next;
         out_data     <= out_data_next;
         out_address  <= out_address_next;
         checksum     <= checksum_next;
      end
   end

   // Next-state and output decode. Status outputs (chip_operation, out_valid,
   // busy, done) depend only on the current state, so abort and reset reach
   // them through the state register. Abort is checked ahead of the normal
   // transitions so it beats both start and a SEND handshake; on abort the
   // datapath simply holds, since the next start reinitialises it anyway.
   always_comb begin
      state_next        = state;
      settle_count_next = settle_count;
      address_next      = chip_address;
      out_data_next     = out_data;
      out_address_next  = out_address;
      checksum_next     = checksum;
      chip_operation    = 4'b0000;
      out_valid         = 1'b0;
      busy              = 1'b1;
      done              = 1'b0;

      case (state)
         IDLE:    busy = 1'b0;
         SETTLE:  chip_operation = READ_OPERATION;
         CAPTURE: chip_operation = READ_OPERATION;
         SEND: begin
            chip_operation = READ_OPERATION;
            out_valid      = 1'b1;
         end
         FINISH:  done = 1'b1;
         default: busy = 1'b1;
      endcase

      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next        = SETTLE;
                  address_next      = '0;
                  checksum_next     = '0;
                  settle_count_next = '0;
               end
            end
            SETTLE: begin
               // The counter starts at zero on entry, so reaching
               // SETTLE_CYCLES-1 means this is the last settle cycle.
               if (settle_count == SETTLE_LAST) begin
                  state_next = CAPTURE;
               end else begin
                  settle_count_next = settle_count + 8'd1;
               end
            end
            CAPTURE: begin
               out_data_next    = chip_data_in;
               out_address_next = chip_address;
               checksum_next    = checksum + 16'(chip_data_in);
               state_next       = SEND;
            end
            SEND: begin
               if (out_ready) begin
                  // The final address is left on the bus rather than wrapped
                  // so the ROM is never touched outside the dump range.
                  if (chip_address == LAST_ADDR) begin
                     state_next = FINISH;
                  end else begin
                     address_next      = chip_address + ADDRESS_WIDTH'(1);
                     settle_count_next = '0;
                     state_next        = SETTLE;
                  end
               end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

endmodule
